// File: rtl/peak_pkg.sv
// Shared constants and event-record layout for the peak readout path.
// The serializer imports this to unpack records: peak value in the MSBs, timestamp in the LSBs.
package peak_pkg;

    localparam int PK_DATA_W = 8;
    localparam int PK_TS_W   = 16;
    localparam int PK_REC_W  = PK_DATA_W + PK_TS_W;

    typedef struct packed {
        logic [PK_DATA_W-1:0] peak;
        logic [PK_TS_W-1:0]   ts;
    } pk_record_t;

    function automatic pk_record_t make_record(input logic [PK_DATA_W-1:0] peak,
                                               input logic [PK_TS_W-1:0]   ts);
        pk_record_t rec;
        rec.peak = peak;
        rec.ts   = ts;
        return rec;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Register-array first-word-fall-through FIFO with explicit occupancy count.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    // Head entry falls through; forced to zero when nothing is stored.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; stale words are never visible because
    // rdata is masked by empty and only written slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/peak_event_buffer.sv
// Turns rising edges of the peak flag into {peak, timestamp} records and queues them
// in a FWFT FIFO for a slow valid/ready readout; dropped records set a sticky flag.
module peak_event_buffer
    import peak_pkg::*;
#(
    parameter int DATA_W = PK_DATA_W,
    parameter int TS_W   = PK_TS_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              pk_detected,
    input  logic [DATA_W-1:0] pk_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_peak,
    output logic [TS_W-1:0]   out_ts,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overflow
);

    localparam int REC_W = DATA_W + TS_W;

    logic [TS_W-1:0]  ts;
    logic             pk_prev;
    logic             event_hit;
    logic             drop;
    logic             empty;
    logic [REC_W-1:0] head;
    logic [REC_W-1:0] record;

    assign event_hit = enable && pk_detected && !pk_prev;
    assign record    = {pk_data, ts};

    // A full FIFO loses the record unless the reader frees a slot in the same cycle.
    assign drop = event_hit && full && !out_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            pk_prev  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pk_prev <= pk_detected;
            if (clear) begin
                ts       <= '0;
                overflow <= 1'b0;
            end else begin
                if (enable) ts <= ts + 1'b1;
                if (drop)   overflow <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH  (REC_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (event_hit),
        .pop   (out_ready),
        .wdata (record),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_peak  = head[REC_W-1 -: DATA_W];
    assign out_ts    = head[TS_W-1:0];

endmodule

// File: tb/tb_peak_event_buffer.sv
// Self-checking bench for peak_event_buffer: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model of the event buffer.
module tb_peak_event_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        pk_detected = 1'b0;
    logic [7:0]  pk_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_peak;
    logic [15:0] out_ts;
    logic [4:0]  count;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [23:0] q[$];
    int          m_ts = 0;
    bit          m_prev = 1'b0;
    bit          m_ovf = 1'b0;

    peak_event_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear       (clear),
        .pk_detected (pk_detected),
        .pk_data     (pk_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_peak    (out_peak),
        .out_ts      (out_ts),
        .count       (count),
        .full        (full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] m_head();
        return (q.size() != 0) ? q[0] : 24'h0;
    endfunction

    function automatic logic [4:0] m_count();
        return 5'(q.size());
    endfunction

    task automatic model_reset();
        q.delete();
        m_ts   = 0;
        m_prev = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Advance the model with the inputs currently applied, then let the DUT take the edge.
    task automatic tick();
        bit evt;
        bit pop;
        bit was_full;
        evt      = enable && pk_detected && !m_prev;
        pop      = (q.size() != 0) && out_ready;
        was_full = (q.size() == DEPTH);
        if (clear) begin
            q.delete();
            m_ovf = 1'b0;
            m_ts  = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (evt) begin
                if (was_full && !pop) m_ovf = 1'b1;
                else q.push_back({pk_data, 16'(m_ts)});
            end
            if (enable) m_ts = (m_ts + 1) % 65536;
        end
        m_prev = pk_detected;
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [7:0] value);
        pk_detected = 1'b1;
        pk_data     = value;
        tick();
        pk_detected = 1'b0;
        tick();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({out_valid, full, overflow, count, out_peak, out_ts} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%0b full=%0b ovf=%0b count=%0d peak=%0d ts=%0d, expected all zero",
                     out_valid, full, overflow, count, out_peak, out_ts);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_event();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        pk_detected = 1'b1;
        pk_data     = 8'd130;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_peak !== 8'd130 || out_ts !== 16'd10 || count !== 5'd1) begin
            bad++;
            $display("FAIL single_event: got valid=%0b peak=%0d ts=%0d count=%0d, expected 1/130/10/1",
                     out_valid, out_peak, out_ts, count);
        end
        pk_data = 8'd77;
        tick();
        tick();
        total++;
        if (count !== 5'd1 || out_peak !== 8'd130) begin
            bad++;
            $display("FAIL single_held_flag: got count=%0d peak=%0d, expected 1/130", count, out_peak);
        end
        pk_detected = 1'b0;
        drain();
    endtask

    task automatic test_burst_order();
        logic [7:0] vals [5];
        vals = '{8'd130, 8'd120, 8'd110, 8'd100, 8'd90};
        for (int i = 0; i < 5; i++) fire(vals[i]);
        total++;
        if (count !== 5'd5) begin
            bad++;
            $display("FAIL burst_count: got %0d, expected 5", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_peak !== vals[i] || {out_peak, out_ts} !== m_head()) begin
                bad++;
                $display("FAIL burst_pop%0d: got valid=%0b peak=%0d ts=%0d, expected peak=%0d ts=%0d",
                         i, out_valid, out_peak, out_ts, vals[i], m_head() & 24'hFFFF);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            bad++;
            $display("FAIL burst_empty: got valid=%0b count=%0d, expected 0/0", out_valid, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) fire(8'(i * 3 + 1));
        total++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_state: got count=%0d full=%0b ovf=%0b, expected 16/1/1", count, full, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (out_peak !== 8'(i * 3 + 1) || {out_peak, out_ts} !== m_head()) begin
                bad++;
                $display("FAIL overflow_order%0d: got peak=%0d, expected %0d", i, out_peak, i * 3 + 1);
            end
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_17th_absent: got valid=%0b ovf=%0b, expected 0/1", out_valid, overflow);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 16; i++) fire(8'(200 + i));
        pk_detected = 1'b1;
        pk_data     = 8'd99;
        out_ready   = 1'b1;
        tick();
        pk_detected = 1'b0;
        out_ready   = 1'b0;
        total++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || out_peak !== 8'd201) begin
            bad++;
            $display("FAIL full_push_pop: got count=%0d full=%0b ovf=%0b peak=%0d, expected 16/1/0/201",
                     count, full, overflow, out_peak);
        end
        drain();
        total++;
        if (m_prev !== 1'b0 || count !== 5'd0) begin
            bad++;
            $display("FAIL full_push_pop_drain: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_push_pop_same();
        fire(8'd10);
        fire(8'd20);
        fire(8'd30);
        pk_detected = 1'b1;
        pk_data     = 8'd40;
        out_ready   = 1'b1;
        tick();
        pk_detected = 1'b0;
        out_ready   = 1'b0;
        total++;
        if (count !== 5'd3 || out_peak !== 8'd20) begin
            bad++;
            $display("FAIL push_pop_count: got count=%0d peak=%0d, expected 3/20", count, out_peak);
        end
        out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (out_peak !== 8'd40 || {out_peak, out_ts} !== m_head() || count !== 5'd1) begin
            bad++;
            $display("FAIL push_pop_tail: got peak=%0d count=%0d, expected 40/1", out_peak, count);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 17; i++) fire(8'(50 + i));
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        out_ready = 1'b0;
        total++;
        if (count !== 5'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL clear_setup: got count=%0d ovf=%0b, expected 4/1", count, overflow);
        end
        clear       = 1'b1;
        pk_detected = 1'b1;
        pk_data     = 8'd222;
        tick();
        clear = 1'b0;
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_peak !== 8'd0) begin
            bad++;
            $display("FAIL clear_effect: got count=%0d valid=%0b ovf=%0b peak=%0d, expected 0/0/0/0",
                     count, out_valid, overflow, out_peak);
        end
        enable      = 1'b0;
        pk_detected = 1'b0;
        tick();
        enable      = 1'b1;
        pk_detected = 1'b1;
        pk_data     = 8'd33;
        tick();
        pk_detected = 1'b0;
        total++;
        if (out_ts !== 16'd0 || out_peak !== 8'd33 || count !== 5'd1) begin
            bad++;
            $display("FAIL clear_ts_zero: got ts=%0d peak=%0d count=%0d, expected 0/33/1", out_ts, out_peak, count);
        end
        drain();
    endtask

    task automatic test_enable_off();
        logic [15:0] frozen;
        frozen = 16'(m_ts);
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pk_detected = i[0];
            pk_data     = 8'(i);
            tick();
        end
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_off_capture: got count=%0d valid=%0b, expected 0/0", count, out_valid);
        end
        pk_detected = 1'b0;
        tick();
        enable      = 1'b1;
        pk_detected = 1'b1;
        pk_data     = 8'd66;
        tick();
        pk_detected = 1'b0;
        total++;
        if (out_ts !== frozen || count !== 5'd1) begin
            bad++;
            $display("FAIL enable_off_ts_frozen: got ts=%0d count=%0d, expected %0d/1", out_ts, count, frozen);
        end
        drain();
    endtask

    task automatic test_ts_wrap();
        int guard;
        clear = 1'b1;
        tick();
        clear  = 1'b0;
        enable = 1'b1;
        guard  = 0;
        while (m_ts != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        pk_detected = 1'b1;
        pk_data     = 8'hAA;
        tick();
        pk_detected = 1'b0;
        tick();
        pk_detected = 1'b1;
        pk_data     = 8'hBB;
        tick();
        pk_detected = 1'b0;
        total++;
        if (out_ts !== 16'hFFFF || out_peak !== 8'hAA || count !== 5'd2) begin
            bad++;
            $display("FAIL ts_wrap_first: got ts=%h peak=%h count=%0d, expected ffff/aa/2", out_ts, out_peak, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_ts !== 16'h0001 || out_peak !== 8'hBB) begin
            bad++;
            $display("FAIL ts_wrap_second: got ts=%h peak=%h, expected 0001/bb", out_ts, out_peak);
        end
        drain();
    endtask

    task automatic test_async_reset();
        fire(8'd11);
        fire(8'd12);
        pk_detected = 1'b1;
        pk_data     = 8'd13;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, full, overflow, count, out_peak, out_ts} !== '0) begin
            bad++;
            $display("FAIL async_reset: got valid=%0b count=%0d peak=%0d ts=%0d, expected all zero",
                     out_valid, count, out_peak, out_ts);
        end
        pk_detected = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_release: got count=%0d valid=%0b, expected 0/0", count, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(7) != 0);
            clear       = ($urandom_range(40) == 0);
            pk_detected = $urandom_range(1);
            pk_data     = 8'($urandom);
            out_ready   = ($urandom_range(3) == 0);
            tick();
            total++;
            if (out_valid !== (q.size() != 0) || {out_peak, out_ts} !== m_head() ||
                count !== m_count() || full !== (q.size() == DEPTH) || overflow !== m_ovf) begin
                bad++;
                $display("FAIL random_step%0d: got valid=%0b rec=%h count=%0d full=%0b ovf=%0b, expected rec=%h count=%0d ovf=%0b",
                         i, out_valid, {out_peak, out_ts}, count, full, overflow, m_head(), m_count(), m_ovf);
            end
        end
        clear     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst_order();
        test_overflow();
        test_push_pop_same();
        test_clear();
        test_enable_off();
        test_ts_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peak_event_buffer.md
Name: peak_event_buffer

Overview:
- Sits directly downstream of PeakDetector and consumes its pkDetected and DOut outputs.
- Converts each new peak into an event record {peak value, timestamp} and stores it in a small first-word-fall-through FIFO.
- Presents the records on a valid/ready interface to the readout/serializer stage (UART framer), so bursts of peaks are not lost while readout is slow.

Parameters:
- DATA_W, 8: width of the peak value; matches DOut.
- TS_W, 16: width of the free-running timestamp counter.
- DEPTH, 16: number of FIFO entries; must be a power of 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  enables timestamp counting and event capture.
- clear  in  1  synchronous flush: empties the FIFO, clears overflow, zeroes the timestamp.
- pk_detected  in  1  peak flag from PeakDetector; may stay high for several cycles.
- pk_data  in  DATA_W  peak value from PeakDetector (DOut); sampled in the capture cycle.
- out_valid  out  1  head record available.
- out_ready  in  1  downstream accepts the head record.
- out_peak  out  DATA_W  peak value of the head record.
- out_ts  out  TS_W  timestamp of the head record.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: at least one event was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - ts counter, FIFO pointers, count, pk_prev and overflow go to 0.
  - out_valid=0, full=0, out_peak=0, out_ts=0.
- Timestamp:
  - ts increments by 1 each cycle while enable=1 and holds otherwise.
  - It wraps modulo 2^TS_W, from 0xFFFF to 0x0000, with no flag.
- Edge detect:
  - pk_prev is a register of pk_detected, updated every cycle regardless of enable.
  - An event occurs when enable && pk_detected && !pk_prev.
  - pk_detected held high for N cycles yields exactly 1 event. A new rising edge is needed for the next event.
- Capture:
  - In the event cycle, the record {pk_data, ts} is formed from the values present in that same cycle (ts before its increment) and pushed.
  - Latency: the event at cycle k gives out_valid=1 at cycle k+1 when the FIFO was empty.
- Pop:
  - A pop occurs on any cycle with out_valid && out_ready.
  - out_peak and out_ts always show the head entry (FWFT). They are 0 when the FIFO is empty.
- Push while full:
  - If there is no pop in the same cycle, the record is dropped, overflow is set to 1, and FIFO contents are unchanged.
  - If there is a pop in the same cycle, both the push and the pop happen and count stays at DEPTH.
- Push and pop together when not full: both happen and count is unchanged.
- Push while empty: out_valid is 0, so no pop is possible; count goes 0->1.
- Pointers are ADDR_W bits and wrap naturally. count is tracked explicitly.
- clear has priority over push and pop:
  - Next cycle: count=0, out_valid=0, overflow=0, ts=0.
  - An event in the clear cycle is discarded. pk_prev still updates.
- enable=0: no events are captured and ts holds. Stored records remain poppable.
- overflow clears only on clear or reset.
- Once out_valid=1, the head record must not change until it is popped, except by clear or reset.

Decomposition:
- Shared package peak_pkg holds the constants PK_DATA_W=8 and PK_TS_W=16, plus the record layout (peak in the MSBs, ts in the LSBs) for reuse by the serializer.
- One sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH), holds the register-array FIFO with push/pop/full/empty/count.
- The top level holds the ts counter, edge detect, drop/overflow logic and clear.

Test Plan:
- Single event: reset, enable=1, pk_detected high for 3 cycles with pk_data=130 at rising edge, ts=10 -> exactly one record, out_valid high next cycle, out_peak=130, out_ts=10, count=1.
- Burst and order: 5 edge events with values 130,120,110,100,90, out_ready=0 -> count=5. Then out_ready=1 -> records pop in that order, one per cycle, and out_valid drops after the 5th.
- Overflow: 17 events with out_ready=0 -> count=16, full=1, overflow=1, the 17th value is absent. A 17th event in a cycle with out_ready=1 -> accepted, count stays 16, overflow unchanged.
- Simultaneous push and pop at count=3 -> count stays 3, with the new record at the tail.
- Timestamp wrap: preload ts to 0xFFFE by running cycles, fire events at ts=0xFFFF and the next at 0x0001 -> out_ts=0xFFFF then 0x0001.
- clear and reset mid-operation:
  - clear asserted with count=4, overflow=1 and an event in the same cycle -> next cycle count=0, overflow=0, ts=0, no record.
  - rst_n pulsed low asynchronously mid-burst -> outputs 0 immediately.
  - enable=0 with pk_detected toggling -> no records and ts frozen.
